alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU. It executes one
// operation at a time; division uses a 32-step restoring divider.
`timescale 1ns/1ps

module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_XOR
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic        id_q, id_d;
    logic        prio_q, prio_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [63:0] result_q, result_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        grant0, grant1, accept, sel;
    logic [2:0]  sel_op;
    logic [31:0] sel_op1, sel_op2;
    logic [63:0] alu_res;
    logic [32:0] sum, diff, rem_shift, trial;

    // prio_q names the requester that wins a tie; it flips only on an accept.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | ~prio_q);
        grant1     = req1_valid & ~grant0;
        req0_ready = (state_q == IDLE) & grant0 & ~rst;
        req1_ready = (state_q == IDLE) & grant1 & ~rst;
        accept     = req0_ready | req1_ready;
        sel        = req1_ready;
        sel_op     = sel ? req1_op  : req0_op;
        sel_op1    = sel ? req1_op1 : req0_op1;
        sel_op2    = sel ? req1_op2 : req0_op2;
    end

    always_comb begin
        sum     = {1'b0, op1_q} + {1'b0, op2_q};
        diff    = {1'b0, op1_q} - {1'b0, op2_q};
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = {31'b0, sum};
            OP_SUB:  alu_res = {31'b0, diff};
            OP_MUL:  alu_res = {32'b0, op1_q} * {32'b0, op2_q};
            OP_DIV:  alu_res = {op1_q, {32{1'b1}}};
            OP_AND:  alu_res = {32'b0, op1_q & op2_q};
            OP_OR:   alu_res = {32'b0, op1_q | op2_q};
            OP_NOT:  alu_res = {32'b0, ~op1_q};
            OP_XOR:  alu_res = {32'b0, op1_q ^ op2_q};
            default: alu_res = '0;
        endcase
        // During DIV, result_q holds {remainder, dividend/quotient shift register}.
        rem_shift = result_q[63:31];
        trial     = rem_shift - {1'b0, op2_q};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        id_d     = id_q;
        prio_d   = prio_q;
        valid_d  = valid_q;
        err_d    = err_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = op_t'(sel_op);
                    op1_d  = sel_op1;
                    op2_d  = sel_op2;
                    id_d   = sel;
                    prio_d = ~sel;
                    if (op_t'(sel_op) == OP_DIV && sel_op2 != '0) begin
                        state_d  = DIV;
                        result_d = {32'b0, sel_op1};
                        cnt_d    = '0;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d = alu_res;
                err_d    = (op_q == OP_DIV);
                valid_d  = 1'b1;
                state_d  = DONE;
            end
            DIV: begin
                if (trial[32])
                    result_d = {rem_shift[31:0], result_q[30:0], 1'b0};
                else
                    result_d = {trial[31:0], result_q[30:0], 1'b1};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            op1_q    <= '0;
            op2_q    <= '0;
            id_q     <= 1'b0;
            prio_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            id_q     <= id_d;
            prio_q   <= prio_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        rsp_valid  = valid_q;
        rsp_id     = id_q;
        rsp_result = result_q;
        rsp_err    = err_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// compared against an arithmetic reference model.
`timescale 1ns/1ps

module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_op1, req0_op2;
    logic        req1_valid, req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_op1, req1_op2;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [63:0] rsp_result;

    int errors = 0;
    int checks = 0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {err, result}
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        logic e;
        e = 1'b0;
        case (op)
            3'd0: r = 64'(a) + 64'(b);
            3'd1: r = {31'b0, (a < b), 32'(a - b)};
            3'd2: r = 64'(a) * 64'(b);
            3'd3: begin
                if (b == 0) begin r = {a, 32'hFFFFFFFF}; e = 1'b1; end
                else r = {32'(a % b), 32'(a / b)};
            end
            3'd4: r = {32'b0, a & b};
            3'd5: r = {32'b0, a | b};
            3'd6: r = {32'b0, ~a};
            default: r = {32'b0, a ^ b};
        endcase
        return {e, r};
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        return (op == 3'd3 && b != 0) ? 33 : 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin
            req0_valid = v; req0_op = op; req0_op1 = a; req0_op2 = b;
        end else begin
            req1_valid = v; req1_op = op; req1_op1 = a; req1_op2 = b;
        end
    endtask

    // Offers one request, scrambles the payload after accept, and returns once
    // rsp_valid is seen. lat counts edges from the start of the accept cycle.
    task automatic issue(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic id, output logic [63:0] res, output logic err, output bit ok);
        logic acc;
        bit got;
        ok = 1'b0;
        got = 1'b0;
        lat = 0;
        drive_req(i, 1'b1, op, a, b);
        for (int w = 0; w < 100 && !ok; w++) begin
            #1;
            acc = (i == 0) ? req0_ready : req1_ready;
            step();
            if (acc) ok = 1'b1;
        end
        drive_req(i, 1'b0, 3'($urandom), $urandom, $urandom);
        if (ok) begin
            lat = 1;
            for (int w = 0; w < 60 && !got; w++) begin
                if (rsp_valid) got = 1'b1;
                else begin step(); lat++; end
            end
        end
        ok = ok && got;
        id = rsp_id;
        res = rsp_result;
        err = rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive_req(0, 1'b1, 3'd0, 32'd1, 32'd2);
        drive_req(1, 1'b1, 3'd0, 32'd3, 32'd4);
        step();
        step();
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        if (rsp_valid !== 1'b0) errors++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) errors++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_result !== 64'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_payload: got id=%b res=%h err=%b expected 0 0 0", rsp_id, rsp_result, rsp_err);
        end
        drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        int lat; logic id; logic [63:0] res; logic err; bit ok;
        issue(0, 3'd0, 32'hFFFFFFFF, 32'd1, lat, id, res, err, ok);
        checks++; if (!ok || lat !== 2 || id !== 1'b0 || res !== 64'h0000000100000000 || err !== 1'b0) begin
            errors++; $display("FAIL add_carry: got ok=%0d lat=%0d id=%b res=%h err=%b expected lat=2 id=0 res=0000000100000000 err=0", ok, lat, id, res, err);
        end
        step();
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL add_release: got busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
        end
        issue(1, 3'd3, 32'd100, 32'd7, lat, id, res, err, ok);
        checks++; if (!ok || lat !== 33 || id !== 1'b1 || res !== {32'd2, 32'd14} || err !== 1'b0) begin
            errors++; $display("FAIL div_100_7: got ok=%0d lat=%0d id=%b res=%h err=%b expected lat=33 id=1 res=000000020000000e err=0", ok, lat, id, res, err);
        end
        step();
        issue(0, 3'd3, 32'd5, 32'd0, lat, id, res, err, ok);
        checks++; if (!ok || lat !== 2 || id !== 1'b0 || res !== 64'h00000005FFFFFFFF || err !== 1'b1) begin
            errors++; $display("FAIL div_zero: got ok=%0d lat=%0d id=%b res=%h err=%b expected lat=2 id=0 res=00000005ffffffff err=1", ok, lat, id, res, err);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        logic [31:0] ea, eb;
        logic r0, r1;
        int g, lat;
        bit got;
        rsp_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ra[0] = 32'hFFFFFFFF; rb[0] = 32'hFFFFFFFF;
        ra[1] = $urandom;     rb[1] = $urandom;
        drive_req(0, 1'b1, 3'd2, ra[0], rb[0]);
        drive_req(1, 1'b1, 3'd2, ra[1], rb[1]);
        for (int k = 0; k < 6; k++) begin
            #1;
            r0 = req0_ready;
            r1 = req1_ready;
            checks++; if (r0 === r1) begin
                errors++; $display("FAIL rr_one_ready[%0d]: got ready0=%b ready1=%b expected exactly one", k, r0, r1);
            end
            g = r1 ? 1 : 0;
            checks++; if (g !== k % 2) begin
                errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, g, k % 2);
            end
            ea = ra[g];
            eb = rb[g];
            step();
            ra[g] = $urandom;
            rb[g] = $urandom;
            drive_req(g, 1'b1, 3'd2, ra[g], rb[g]);
            lat = 1;
            got = 1'b0;
            for (int w = 0; w < 60 && !got; w++) begin
                if (rsp_valid) got = 1'b1;
                else begin step(); lat++; end
            end
            checks++; if (!got || lat !== 2) begin
                errors++; $display("FAIL rr_latency[%0d]: got %0d expected 2", k, lat);
            end
            checks++; if (rsp_id !== 1'(g) || rsp_result !== model(3'd2, ea, eb)) begin
                errors++; $display("FAIL rr_rsp[%0d]: got id=%b res=%h expected id=%0d res=%h", k, rsp_id, rsp_result, g, model(3'd2, ea, eb));
            end
            step();
        end
        drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_backpressure();
        int lat; logic id; logic [63:0] res; logic err; bit ok;
        logic [31:0] a, b;
        logic [64:0] e;
        a = $urandom;
        b = $urandom;
        e = model(3'd7, a, b);
        rsp_ready = 1'b0;
        issue(0, 3'd7, a, b, lat, id, res, err, ok);
        checks++; if (!ok || lat !== 2 || res !== e[63:0] || id !== 1'b0) begin
            errors++; $display("FAIL bp_first: got ok=%0d lat=%0d id=%b res=%h expected lat=2 id=0 res=%h", ok, lat, id, res, e[63:0]);
        end
        drive_req(0, 1'b1, 3'd4, 32'h1234, 32'h5678);
        drive_req(1, 1'b1, 3'd0, 32'd40, 32'd2);
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== e[63:0] || rsp_id !== 1'b0 || rsp_err !== 1'b0
                          || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b res=%h id=%b err=%b rdy=%b%b busy=%b expected v=1 res=%h id=0 err=0 rdy=00 busy=1",
                    c, rsp_valid, rsp_result, rsp_id, rsp_err, req0_ready, req1_ready, busy, e[63:0]);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL bp_release: got v=%b busy=%b rdy=%b%b expected v=0 busy=0 rdy=01", rsp_valid, busy, req0_ready, req1_ready);
        end
        drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(1, 3'd0, 32'd40, 32'd2, lat, id, res, err, ok);
        checks++; if (!ok || lat !== 2 || id !== 1'b1 || res !== 64'd42) begin
            errors++; $display("FAIL bp_next: got ok=%0d lat=%0d id=%b res=%h expected lat=2 id=1 res=42", ok, lat, id, res);
        end
        step();
    endtask

    task automatic test_reset_mid_div();
        int lat; logic id; logic [63:0] res; logic err; bit ok;
        rsp_ready = 1'b1;
        drive_req(0, 1'b1, 3'd3, 32'hDEADBEEF, 32'd3);
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            #1;
            ok = req0_ready;
            step();
        end
        drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++; if (!ok) begin errors++; $display("FAIL rdiv_accept: got no accept expected accept"); end
        for (int c = 0; c < 10; c++) step();
        rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rdiv_abort: got busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
        end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rdiv_ghost[%0d]: got rsp_valid=%b expected 0", c, rsp_valid);
            end
            step();
        end
        checks++;
        drive_req(0, 1'b1, 3'd1, 32'd3, 32'd5);
        drive_req(1, 1'b1, 3'd5, 32'hF0, 32'h0F);
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rdiv_prio: got rdy=%b%b expected rdy=10", req0_ready, req1_ready);
        end
        drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(0, 3'd1, 32'd3, 32'd5, lat, id, res, err, ok);
        checks++; if (!ok || lat !== 2 || id !== 1'b0 || res !== 64'h00000001FFFFFFFE || err !== 1'b0) begin
            errors++; $display("FAIL rdiv_after: got ok=%0d lat=%0d id=%b res=%h err=%b expected lat=2 id=0 res=00000001fffffffe err=0", ok, lat, id, res, err);
        end
        step();
    endtask

    task automatic test_random();
        int lat; logic id; logic [63:0] res; logic err; bit ok;
        int i;
        logic [2:0] op;
        logic [31:0] a, b;
        logic [64:0] e;
        rsp_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            i = $urandom_range(0, 1);
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            b = $urandom;
            if (op == 3'd3) begin
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = $urandom_range(1, 15);
                    default: b = $urandom;
                endcase
            end
            e = model(op, a, b);
            issue(i, op, a, b, lat, id, res, err, ok);
            checks++; if (!ok || lat !== exp_lat(op, b)) begin
                errors++; $display("FAIL rnd_latency[%0d] op=%0d: got ok=%0d lat=%0d expected %0d", n, op, ok, lat, exp_lat(op, b));
            end
            checks++; if (id !== 1'(i)) begin
                errors++; $display("FAIL rnd_id[%0d]: got %b expected %0d", n, id, i);
            end
            checks++; if (res !== e[63:0] || err !== e[64]) begin
                errors++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: got %h err=%b expected %h err=%b", n, op, a, b, res, err, e[63:0], e[64]);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_mid_div();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
